// File: rtl/tagged_mem_responder.sv
// Memory-side responder for the CPU external port: tagged word RAM with a latched,
// auto-incrementing word pointer, plus sticky error and read/write activity counters.
module tagged_mem_responder #(
   parameter int unsigned AW = 20,
   parameter int unsigned DW = 64,
   parameter int unsigned TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] i_ad,
   input  logic [TW-1:0] i_tag,
   input  logic          i_astb,
   input  logic          i_rd,
   input  logic          i_wr,
   output logic [DW-1:0] o_data,
   output logic [TW-1:0] o_tag,
   output logic [AW-1:0] o_addr,
   output logic          o_err,
   output logic [31:0]   o_nrd,
   output logic [31:0]   o_nwr
);

   localparam int unsigned DEPTH = 2**AW;
   localparam int unsigned CW    = 32;

   logic [DW-1:0] mem_data [DEPTH];
   logic [TW-1:0] mem_tag  [DEPTH];

   logic          addr_valid;
   logic          strobe_c;
   logic          wr_c;
   logic          rd_c;
   logic          high_bits_c;
   logic          err_set_c;
   logic [AW-1:0] addr_inc_c;

   // Command decode: strobe beats write beats read; losers are dropped entirely.
   always_comb begin
      strobe_c    = i_astb;
      wr_c        = i_wr & ~i_astb;
      rd_c        = i_rd & ~i_astb & ~i_wr;
      high_bits_c = (i_ad[DW-1:AW] != '0);
      addr_inc_c  = o_addr + AW'(1);
      err_set_c   = (strobe_c & high_bits_c) | ((wr_c | rd_c) & ~addr_valid);
   end

   // Pointer, sticky error and activity counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_addr     <= '0;
         addr_valid <= 1'b0;
         o_err      <= 1'b0;
         o_nrd      <= '0;
         o_nwr      <= '0;
      end else begin
         if (err_set_c) begin
            o_err <= 1'b1;
         end
         if (strobe_c) begin
            o_addr     <= i_ad[AW-1:0];
            addr_valid <= 1'b1;
         end else if (wr_c) begin
            o_addr <= addr_inc_c;
            o_nwr  <= o_nwr + CW'(1);
         end else if (rd_c) begin
            o_addr <= addr_inc_c;
            o_nrd  <= o_nrd + CW'(1);
         end
      end
   end

   // Single-port RAM write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_c) begin
         mem_data[o_addr] <= i_ad;
         mem_tag[o_addr]  <= i_tag;
      end
   end

   // Registered read port; holds the last loaded word between reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_data <= '0;
         o_tag  <= '0;
      end else if (rd_c) begin
         o_data <= mem_data[o_addr];
         o_tag  <= mem_tag[o_addr];
      end
   end

endmodule

// File: tb/tb_tagged_mem_responder.sv
// Directed bench for tagged_mem_responder: strobe/read/write sequences with
// hand-computed expectations for data, tags, pointer, error flag and counters.
module tb_tagged_mem_responder;

   logic        clk;
   logic        rst_n;
   logic [63:0] ad;
   logic [7:0]  tag;
   logic        astb;
   logic        rd;
   logic        wr;
   logic [63:0] data;
   logic [7:0]  tag_out;
   logic [19:0] addr;
   logic        err;
   logic [31:0] nrd;
   logic [31:0] nwr;

   int vectors;
   int miscompares;

   tagged_mem_responder dut (
      .clk    (clk),
      .reset  (rst_n),
      .i_ad   (ad),
      .i_tag  (tag),
      .i_astb (astb),
      .i_rd   (rd),
      .i_wr   (wr),
      .o_data (data),
      .o_tag  (tag_out),
      .o_addr (addr),
      .o_err  (err),
      .o_nrd  (nrd),
      .o_nwr  (nwr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", name, observed, expected);
      end
   endtask

   task automatic apply(input logic s, input logic w, input logic r,
                        input logic [63:0] a, input logic [7:0] t);
      @(negedge clk);
      astb = s; wr = w; rd = r; ad = a; tag = t;
      @(posedge clk);
      #1;
      astb = 1'b0; wr = 1'b0; rd = 1'b0;
   endtask

   task automatic strobe(input logic [63:0] a);
      apply(1'b1, 1'b0, 1'b0, a, 8'h00);
   endtask

   task automatic write(input logic [63:0] d, input logic [7:0] t);
      apply(1'b0, 1'b1, 1'b0, d, t);
   endtask

   task automatic read();
      apply(1'b0, 1'b0, 1'b1, 64'h0, 8'h00);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_rst_addr", 64'(addr), 64'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      ad = '0; tag = '0; astb = 1'b0; rd = 1'b0; wr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_data", data, 64'h0);
      check("rst_tag", 64'(tag_out), 64'h0);
      check("rst_addr", 64'(addr), 64'h0);
      check("rst_err", 64'(err), 64'h0);
      check("rst_nrd", 64'(nrd), 64'h0);
      check("rst_nwr", 64'(nwr), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic write batch then read batch
      strobe(64'h10);
      write(64'hDEADBEEF_00000001, 8'h15);
      write(64'hDEADBEEF_00000002, 8'h16);
      check("t1_addr_after_wr", 64'(addr), 64'h12);
      strobe(64'h10);
      read();
      check("t1_rd0_data", data, 64'hDEADBEEF_00000001);
      check("t1_rd0_tag", 64'(tag_out), 64'h15);
      read();
      check("t1_rd1_data", data, 64'hDEADBEEF_00000002);
      check("t1_rd1_tag", 64'(tag_out), 64'h16);
      check("t1_nwr", 64'(nwr), 64'd2);
      check("t1_nrd", 64'(nrd), 64'd2);
      check("t1_err", 64'(err), 64'h0);
      check("t1_addr", 64'(addr), 64'h12);
      apply(1'b0, 1'b0, 1'b0, 64'h0, 8'h0);
      check("idle_hold_data", data, 64'hDEADBEEF_00000002);

      // Strobe wins over a same-cycle write
      strobe(64'h12);
      write(64'h1234_5678_9ABC_DEF0, 8'h33);
      strobe(64'h12);
      apply(1'b1, 1'b1, 1'b0, 64'h20, 8'hEE);
      check("t2_addr", 64'(addr), 64'h20);
      check("t2_nwr", 64'(nwr), 64'd3);
      strobe(64'h12);
      read();
      check("t2_ram_intact", data, 64'h1234_5678_9ABC_DEF0);
      check("t2_tag_intact", 64'(tag_out), 64'h33);
      // Write wins over a same-cycle read
      strobe(64'h40);
      apply(1'b0, 1'b1, 1'b1, 64'hCAFE, 8'h01);
      check("wr_over_rd_nrd", 64'(nrd), 64'd3);
      check("wr_over_rd_nwr", 64'(nwr), 64'd4);

      // Pointer wrap at top of address space
      strobe(64'hFFFFF);
      write(64'hAAAA_AAAA_AAAA_AAAA, 8'hA1);
      check("t3_wrap_addr", 64'(addr), 64'h0);
      write(64'hBBBB_BBBB_BBBB_BBBB, 8'hB2);
      strobe(64'h0);
      read();
      check("t3_data", data, 64'hBBBB_BBBB_BBBB_BBBB);
      check("t3_tag", 64'(tag_out), 64'hB2);
      check("t3_addr", 64'(addr), 64'h1);
      check("t3_err", 64'(err), 64'h0);
      strobe(64'hFFFFF);
      read();
      check("t3_top_data", data, 64'hAAAA_AAAA_AAAA_AAAA);

      // Out-of-range strobe address
      strobe(64'h1_00000005);
      check("t5_addr", 64'(addr), 64'h5);
      check("t5_err", 64'(err), 64'h1);

      pulse_reset();
      check("post_rst_err", 64'(err), 64'h0);
      check("post_rst_nrd", 64'(nrd), 64'h0);

      // Read without a strobe since reset
      read();
      check("t4_err", 64'(err), 64'h1);
      check("t4_nrd", 64'(nrd), 64'd1);
      check("t4_data_persist", data, 64'hBBBB_BBBB_BBBB_BBBB);
      strobe(64'h10);
      read();
      check("t4_valid_data", data, 64'hDEADBEEF_00000001);
      check("t4_err_sticky", 64'(err), 64'h1);
      pulse_reset();
      check("t4_err_cleared", 64'(err), 64'h0);

      // Reset in the middle of a write batch
      strobe(64'h100);
      write(64'h0000_0100_0000_0000, 8'h40);
      write(64'h0000_0101_0000_0001, 8'h41);
      pulse_reset();
      check("t6_nwr_reset", 64'(nwr), 64'h0);
      strobe(64'h100);
      read();
      check("t6_rd0", data, 64'h0000_0100_0000_0000);
      check("t6_tag0", 64'(tag_out), 64'h40);
      read();
      check("t6_rd1", data, 64'h0000_0101_0000_0001);
      check("t6_tag1", 64'(tag_out), 64'h41);
      check("t6_addr", 64'(addr), 64'h102);
      check("t6_nrd", 64'(nrd), 64'd2);
      check("t6_nwr", 64'(nwr), 64'd0);
      check("t6_err", 64'(err), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
